// File: rtl/prog_run_sequencer.sv
// Launcher for a processor core: holds it in reset, runs it until done or a cycle limit,
// then reads the selected program's result bytes back through a data-memory read port.
module prog_run_sequencer #(
    parameter int unsigned RST_CYC = 3,
    parameter logic [15:0] MAX_CYC = 16'hFFFF,
    parameter logic [7:0]  A_P1_HI = 8'd4,
    parameter logic [7:0]  A_P2    = 8'd7,
    parameter logic [7:0]  A_P3    = 8'd127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [1:0]  prog_sel,
    input  logic        core_done,
    output logic        core_reset,
    output logic [7:0]  dm_raddr,
    input  logic [7:0]  dm_rdata,
    output logic        busy,
    output logic [15:0] result,
    output logic        result_valid,
    output logic [15:0] cycles,
    output logic        timeout,
    output logic        bad_sel
);

    typedef enum logic [2:0] {IDLE, HOLD, RUN, RD_HI, RD_LO, FIN} state_t;

    state_t      state, next_state;
    logic [1:0]  sel;
    logic [7:0]  hold_cnt;
    logic [15:0] cyc_inc;
    logic        hold_last;
    logic [7:0]  lo_addr;

    always_comb begin
        cyc_inc   = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
        hold_last = (hold_cnt == 8'(RST_CYC - 1));
        case (sel)
            2'd0:    lo_addr = A_P1_HI + 8'd1;
            2'd1:    lo_addr = A_P2;
            default: lo_addr = A_P3;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (go && prog_sel != 2'd3) next_state = HOLD;
            HOLD:  if (hold_last) next_state = RUN;
            RUN: begin
                // done takes priority over the cycle limit on the same cycle
                if (core_done)              next_state = (sel == 2'd0) ? RD_HI : RD_LO;
                else if (cyc_inc >= MAX_CYC) next_state = FIN;
            end
            RD_HI: next_state = RD_LO;
            RD_LO: next_state = FIN;
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        core_reset = (state != RUN);
        busy       = (state == HOLD) || (state == RUN) || (state == RD_HI) || (state == RD_LO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel          <= 2'd0;
            hold_cnt     <= 8'd0;
            cycles       <= 16'd0;
            timeout      <= 1'b0;
            result       <= 16'd0;
            result_valid <= 1'b0;
            bad_sel      <= 1'b0;
            dm_raddr     <= 8'd0;
        end else begin
            result_valid <= (state == RD_LO);
            bad_sel      <= (state == IDLE) && go && (prog_sel == 2'd3);

            case (state)
                IDLE: begin
                    if (next_state == HOLD) begin
                        sel      <= prog_sel;
                        timeout  <= 1'b0;
                        hold_cnt <= 8'd0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_last) cycles <= 16'd0;
                end
                RUN: begin
                    cycles <= cyc_inc;
                    if (next_state == FIN) timeout <= 1'b1;
                end
                RD_HI: result[15:8] <= dm_rdata;
                RD_LO: begin
                    result[7:0] <= dm_rdata;
                    if (sel != 2'd0) result[15:8] <= 8'd0;
                end
                default: ;
            endcase

            // Address is set on the edge entering a read state so the asynchronous
            // memory returns data within that state; otherwise it holds.
            if (next_state == RD_HI)      dm_raddr <= A_P1_HI;
            else if (next_state == RD_LO) dm_raddr <= lo_addr;
        end
    end

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Directed bench for prog_run_sequencer: table of program runs plus hand-written
// sequences for reset, illegal select and reset during a run.
module tb_prog_run_sequencer;

    localparam int unsigned RST_CYC = 3;
    localparam logic [15:0] MAX_CYC = 16'd50;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [1:0]  prog_sel;
    logic        core_done;
    logic        core_reset;
    logic [7:0]  dm_raddr;
    logic [7:0]  dm_rdata;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic [15:0] cycles;
    logic        timeout;
    logic        bad_sel;

    logic [7:0] mem [256];
    assign dm_rdata = mem[dm_raddr];

    int n_checks = 0;
    int n_fail   = 0;

    prog_run_sequencer #(
        .RST_CYC(RST_CYC),
        .MAX_CYC(MAX_CYC),
        .A_P1_HI(8'd4),
        .A_P2   (8'd7),
        .A_P3   (8'd127)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .prog_sel    (prog_sel),
        .core_done   (core_done),
        .core_reset  (core_reset),
        .dm_raddr    (dm_raddr),
        .dm_rdata    (dm_rdata),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .cycles      (cycles),
        .timeout     (timeout),
        .bad_sel     (bad_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  hi_byte;
        logic [7:0]  lo_byte;
        int          done_after;  // RUN cycle that carries done; 0 = never
        int          go_in_run;   // RUN cycle carrying a stray go; 0 = none
        logic        go_in_fin;
        logic [15:0] exp_result;
        logic [15:0] exp_cycles;
        logic        exp_timeout;
        logic [7:0]  exp_raddr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int k;
        if (v.sel == 2'd0) begin
            mem[4] = v.hi_byte;
            mem[5] = v.lo_byte;
        end else if (v.sel == 2'd1) begin
            mem[7] = v.lo_byte;
        end else begin
            mem[127] = v.lo_byte;
        end

        go = 1'b1;
        prog_sel = v.sel;
        tick();
        go = 1'b0;
        prog_sel = 2'd3;  // select must have been latched
        check("busy_after_go", busy, 1'b1);
        check("timeout_cleared", timeout, 1'b0);

        lat = 1;
        while (core_reset && lat < 20) begin
            tick();
            lat++;
        end
        check("go_to_run_latency", lat, RST_CYC + 1);

        k = 1;
        forever begin
            core_done = (k == v.done_after);
            if (k == v.go_in_run) begin
                go = 1'b1;
                prog_sel = 2'd0;
            end
            tick();
            core_done = 1'b0;
            go = 1'b0;
            prog_sel = 2'd3;
            if (core_reset || k >= 100) break;
            k++;
        end
        check("run_length", k, v.exp_cycles);

        lat = 1;
        while (busy && lat < 10) begin
            tick();
            lat++;
        end
        if (v.exp_timeout) begin
            check("no_valid_on_timeout", result_valid, 1'b0);
        end else begin
            check("result_valid_pulse", result_valid, 1'b1);
            check("done_to_valid_latency", lat, (v.sel == 2'd0) ? 3 : 2);
        end

        if (v.go_in_fin) begin
            go = 1'b1;
            prog_sel = 2'd1;
        end
        tick();
        go = 1'b0;
        check("valid_single_cycle", result_valid, 1'b0);
        check("idle_not_busy", busy, 1'b0);
        check("idle_core_reset", core_reset, 1'b1);
        check("result", result, v.exp_result);
        check("cycles", cycles, v.exp_cycles);
        check("timeout", timeout, v.exp_timeout);
        check("dm_raddr_hold", dm_raddr, v.exp_raddr);
        tick();
        check("stays_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t extra;
        int k;

        vecs[0] = '{2'd0, 8'h0F, 8'hA8, 20, 0,  1'b0, 16'h0FA8, 16'd20, 1'b0, 8'd5};
        vecs[1] = '{2'd1, 8'h00, 8'd13, 1,  0,  1'b0, 16'd13,   16'd1,  1'b0, 8'd7};
        vecs[2] = '{2'd2, 8'h00, 8'h5A, 8,  3,  1'b0, 16'h005A, 16'd8,  1'b0, 8'd127};
        vecs[3] = '{2'd0, 8'hFF, 8'h01, 3,  0,  1'b1, 16'hFF01, 16'd3,  1'b0, 8'd5};
        vecs[4] = '{2'd2, 8'h00, 8'h33, 0,  0,  1'b0, 16'hFF01, 16'd50, 1'b1, 8'd5};
        vecs[5] = '{2'd1, 8'h00, 8'hC8, 50, 0,  1'b0, 16'h00C8, 16'd50, 1'b0, 8'd7};
        vecs[6] = '{2'd0, 8'h80, 8'h00, 2,  0,  1'b0, 16'h8000, 16'd2,  1'b0, 8'd5};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

        reset = 1'b0;
        go = 1'b0;
        prog_sel = 2'd0;
        core_done = 1'b0;
        #12;
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 16'd0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_cycles", cycles, 16'd0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_bad_sel", bad_sel, 1'b0);
        check("rst_raddr", dm_raddr, 8'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("no_go_core_held", core_reset, 1'b1);
        check("no_go_busy", busy, 1'b0);

        // Illegal select: pulse only, never starts the core
        go = 1'b1;
        prog_sel = 2'd3;
        tick();
        go = 1'b0;
        check("bad_sel_pulse", bad_sel, 1'b1);
        check("bad_sel_busy", busy, 1'b0);
        check("bad_sel_core_reset", core_reset, 1'b1);
        tick();
        check("bad_sel_one_cycle", bad_sel, 1'b0);
        check("bad_sel_still_idle", core_reset, 1'b1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a run
        go = 1'b1;
        prog_sel = 2'd0;
        tick();
        go = 1'b0;
        k = 0;
        while (core_reset && k < 20) begin
            tick();
            k++;
        end
        for (int i = 0; i < 9; i++) tick();
        check("midrun_cycles", cycles, 16'd9);
        check("midrun_running", core_reset, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midrun_rst_core_reset", core_reset, 1'b1);
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_result", result, 16'd0);
        check("midrun_rst_cycles", cycles, 16'd0);
        check("midrun_rst_raddr", dm_raddr, 8'd0);
        check("midrun_rst_valid", result_valid, 1'b0);
        #3;
        reset = 1'b1;
        tick();
        extra = '{2'd2, 8'h00, 8'h6E, 5, 0, 1'b0, 16'h006E, 16'd5, 1'b0, 8'd127};
        run_vec(extra);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
